// File: rtl/pwm_fader_pkg.sv
// pwm_pkg: shared duty limit, state encoding and readback field positions for the fader
package pwm_pkg;
  typedef logic [6:0] duty_t;
  localparam int DUTY_MAX = 100;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam int RD_CUR_LSB  = 0;
  localparam int RD_RATE_LSB = 8;
  localparam int RD_BUSY_BIT = 16;
endpackage

// File: rtl/pwm_fader_if.sv
// pwm_fader_if: register-bus write/readback bundle between a bus master and the fader
interface pwm_fader_if;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  modport master (output WD, output WE, input RD);
  modport slave  (input WD, input WE, output RD);
endinterface

// File: rtl/pwm_fader_tick_gen.sv
// pwm_tick_gen: free-running 0..TICK_DIV-1 counter with a one-cycle tick on its last count
module pwm_tick_gen #(
  parameter int TICK_DIV = 118_877
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick  = cnt_q == W'(TICK_DIV - 1);
  assign cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  // cycle counter, restarted by clr and wrapping after its last count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/pwm_fader.sv
// pwm_fader: ramps a PWM duty value toward a written target one percent per rate ticks
module pwm_fader #(
  parameter int TICK_DIV = 118_877,
  parameter int DUTY_MAX = pwm_pkg::DUTY_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  pwm_fader_if.slave  bus,
  output logic [6:0]  duty_out,
  output logic        duty_we,
  output logic        busy
);
  import pwm_pkg::*;
  logic [1:0] state_q, state_d;
  duty_t      tgt_q, tgt_d, cur_q, cur_d, wt;
  logic [7:0] rate_q, rate_d, tcnt_q, tcnt_d, wr;
  logic       we_q, we_d, tick, last, wd_unused;
  assign wt        = bus.WD[6:0] > 7'(DUTY_MAX) ? 7'(DUTY_MAX) : bus.WD[6:0];
  assign wr        = bus.WD[15:8];
  assign wd_unused = ^{bus.WD[31:16], bus.WD[7]};
  assign last      = {1'b0, tcnt_q} + 9'd1 == {1'b0, rate_q};
  // the tick counter only needs to run while a ramp is pending; any write restarts the wait
  pwm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.WE || state_q == S_IDLE),
    .tick  (tick)
  );
  // next state: a write always wins over a pending step and is judged against the pre-step duty
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    rate_d  = rate_q;
    cur_d   = cur_q;
    tcnt_d  = tcnt_q;
    we_d    = 1'b0;
    if (bus.WE) begin
      tgt_d   = wt;
      rate_d  = wr;
      tcnt_d  = '0;
      cur_d   = (wt != cur_q && wr == '0) ? wt : cur_q;
      we_d    = wt != cur_q && wr == '0;
      state_d = (wt != cur_q && wr != '0) ? S_WAIT : S_IDLE;
    end else if (state_q == S_WAIT && tick) begin
      tcnt_d  = last ? '0 : tcnt_q + 8'd1;
      state_d = last ? S_STEP : S_WAIT;
    end else if (state_q == S_STEP) begin
      cur_d   = tgt_q > cur_q ? cur_q + 7'd1 : cur_q - 7'd1;
      we_d    = 1'b1;
      state_d = cur_d == tgt_q ? S_IDLE : S_WAIT;
    end
  end
  // state registers, all cleared immediately by reset so an aborted ramp leaves no pulse behind
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      rate_q  <= '0;
      cur_q   <= '0;
      tcnt_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      rate_q  <= rate_d;
      cur_q   <= cur_d;
      tcnt_q  <= tcnt_d;
      we_q    <= we_d;
    end
  assign duty_out = cur_q;
  assign duty_we  = we_q;
  assign busy     = tgt_q != cur_q;
  // readback is built purely from registered state
  always_comb begin
    bus.RD = '0;
    bus.RD[RD_BUSY_BIT]     = busy;
    bus.RD[RD_RATE_LSB +: 8] = rate_q;
    bus.RD[RD_CUR_LSB +: 7]  = cur_q;
  end
endmodule

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader: directed and random checks of pwm_fader against a step-schedule model
module tb_pwm_fader;
  localparam int TD = 4;
  localparam int DMAX = 100;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] duty_out;
  logic duty_we, busy;
  int errors = 0, checks = 0, edge_n = 0;
  int m_cur = 0, m_tgt = 0, m_rate = 0, m_next = 0;
  bit m_we = 0;
  pwm_fader_if bus ();
  pwm_fader #(.TICK_DIV(TD), .DUTY_MAX(DMAX)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .duty_out(duty_out), .duty_we(duty_we), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at edge %0d", edge_n);
    $fatal(1);
  end

  function automatic logic [31:0] wdat(input int t, input int r);
    return {16'h0, 8'(r), 1'b0, 7'(t)};
  endfunction

  function automatic logic [40:0] exp_obs();
    logic b;
    b = m_cur != m_tgt;
    return {7'(m_cur), m_we, b, 15'h0, b, 8'(m_rate), 1'b0, 7'(m_cur)};
  endfunction

  function automatic logic [40:0] obs();
    return {duty_out, duty_we, busy, bus.RD};
  endfunction

  task automatic model_reset();
    m_cur = 0; m_tgt = 0; m_rate = 0; m_we = 0; m_next = 0;
  endtask

  task automatic cyc(input bit we, input logic [31:0] wd);
    int t, r;
    @(negedge clk);
    bus.WE = we;
    bus.WD = wd;
    @(posedge clk);
    edge_n++;
    m_we = 0;
    if (we) begin
      t = wd[6:0] > DMAX ? DMAX : int'(wd[6:0]);
      r = int'(wd[15:8]);
      m_tgt = t;
      m_rate = r;
      if (t != m_cur) begin
        if (r == 0) begin m_cur = t; m_we = 1; end
        else m_next = edge_n + r * TD + 1;
      end
    end else if (m_cur != m_tgt && edge_n == m_next) begin
      m_cur += (m_tgt > m_cur) ? 1 : -1;
      m_we = 1;
      m_next = edge_n + m_rate * TD;
    end
    #1;
    bus.WE = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== 41'h0) begin errors++; $display("FAIL reset got=%h exp=%h", obs(), 41'h0); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_jump();
    int pulses = 0, busy_hi = 0;
    cyc(1, wdat(10, 0));
    checks++;
    if (duty_out !== 7'd10 || duty_we !== 1'b1) begin errors++; $display("FAIL jump got duty=%0d we=%b exp duty=10 we=1", duty_out, duty_we); end
    pulses += duty_we; busy_hi |= busy;
    for (int i = 0; i < 8; i++) begin
      cyc(0, '0);
      checks++;
      if (obs() !== exp_obs()) begin errors++; $display("FAIL jump_trace edge=%0d got=%h exp=%h", edge_n, obs(), exp_obs()); end
      pulses += duty_we; busy_hi |= busy;
    end
    checks++;
    if (pulses != 1 || busy_hi != 0) begin errors++; $display("FAIL jump_pulses got pulses=%0d busy=%0d exp 1/0", pulses, busy_hi); end
  endtask

  task automatic test_ramp_up();
    int p[$];
    cyc(1, wdat(0, 0));
    checks++;
    if (obs() !== exp_obs()) begin errors++; $display("FAIL ramp_zero got=%h exp=%h", obs(), exp_obs()); end
    cyc(1, wdat(3, 2));
    checks++;
    if (busy !== 1'b1 || duty_out !== 7'd0) begin errors++; $display("FAIL ramp_busy got busy=%b duty=%0d exp 1/0", busy, duty_out); end
    for (int i = 0; i < 30; i++) begin
      cyc(0, '0);
      checks++;
      if (obs() !== exp_obs()) begin errors++; $display("FAIL ramp_trace edge=%0d got=%h exp=%h", edge_n, obs(), exp_obs()); end
      if (duty_we) p.push_back(edge_n);
    end
    checks++;
    if (p.size() != 3 || p[1] - p[0] != 8 || p[2] - p[1] != 8 || duty_out !== 7'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL ramp_pulses got n=%0d duty=%0d busy=%b exp n=3 spaced 8 duty=3 busy=0", p.size(), duty_out, busy);
    end
  endtask

  task automatic test_clamp();
    int p[$];
    cyc(1, wdat(120, 0));
    checks++;
    if (duty_out !== 7'd100 || bus.RD[6:0] !== 7'd100) begin errors++; $display("FAIL clamp got duty=%0d rd=%0d exp 100", duty_out, bus.RD[6:0]); end
    cyc(1, wdat(98, 1));
    for (int i = 0; i < 15; i++) begin
      cyc(0, '0);
      checks++;
      if (obs() !== exp_obs()) begin errors++; $display("FAIL down_trace edge=%0d got=%h exp=%h", edge_n, obs(), exp_obs()); end
      if (duty_we) p.push_back(edge_n);
    end
    checks++;
    if (p.size() != 2 || p[1] - p[0] != 4 || duty_out !== 7'd98) begin
      errors++; $display("FAIL down_pulses got n=%0d duty=%0d exp n=2 spaced 4 duty=98", p.size(), duty_out);
    end
  endtask

  task automatic test_reverse();
    int w;
    int p[$], v[$];
    cyc(1, wdat(5, 0));
    cyc(1, wdat(20, 1));
    for (int i = 0; i < 3; i++) cyc(0, '0);
    checks++;
    if (duty_out !== 7'd5 || busy !== 1'b1) begin errors++; $display("FAIL rev_setup got duty=%0d busy=%b exp 5/1", duty_out, busy); end
    cyc(1, wdat(2, 1));
    w = edge_n;
    for (int i = 0; i < 20; i++) begin
      cyc(0, '0);
      checks++;
      if (obs() !== exp_obs()) begin errors++; $display("FAIL rev_trace edge=%0d got=%h exp=%h", edge_n, obs(), exp_obs()); end
      if (duty_we) begin p.push_back(edge_n); v.push_back(int'(duty_out)); end
    end
    checks++;
    if (v.size() != 3 || v[0] != 4 || v[1] != 3 || v[2] != 2 || p[0] - w < 4) begin
      errors++; $display("FAIL rev_values got n=%0d first=%0d gap=%0d exp 4,3,2 gap>=4", v.size(), v.size() ? v[0] : -1, p.size() ? p[0] - w : -1);
    end
  endtask

  task automatic test_step_write();
    int k = 0, pre;
    cyc(1, wdat(6, 1));
    while (edge_n + 1 != m_next && k < 20) begin cyc(0, '0); k++; end
    checks++;
    if (k >= 20) begin errors++; $display("FAIL step_wait got timeout exp STEP within 20 cycles"); end
    pre = m_cur;
    checks++;
    if (bus.RD[6:0] !== 7'(pre)) begin errors++; $display("FAIL step_rd_before got=%0d exp=%0d", bus.RD[6:0], pre); end
    cyc(1, wdat(30, 3));
    checks++;
    if (bus.RD[6:0] !== 7'(pre) || duty_we !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL step_discard got rd=%0d we=%b busy=%b exp rd=%0d we=0 busy=1", bus.RD[6:0], duty_we, busy, pre);
    end
    checks++;
    if (obs() !== exp_obs()) begin errors++; $display("FAIL step_model got=%h exp=%h", obs(), exp_obs()); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    for (int i = 0; i < 15; i++) cyc(0, '0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_setup got busy=%b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (duty_out !== 7'd0 || busy !== 1'b0 || duty_we !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort got duty=%0d busy=%b we=%b exp 0/0/0", duty_out, busy, duty_we);
    end
    @(posedge clk);
    edge_n++;
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(0, '0);
      checks++;
      if (obs() !== exp_obs()) begin errors++; $display("FAIL rstmid_trace edge=%0d got=%h exp=%h", edge_n, obs(), exp_obs()); end
      pulses += duty_we;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL rstmid_pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_random();
    logic [31:0] r32;
    bit we;
    int prev;
    for (int i = 0; i < 500; i++) begin
      r32 = $urandom;
      r32[15:8] = 8'($urandom_range(0, 3));
      we = $urandom_range(0, 7) == 0;
      prev = int'(duty_out);
      cyc(we, r32);
      checks++;
      if (obs() !== exp_obs()) begin errors++; $display("FAIL rand_trace edge=%0d got=%h exp=%h", edge_n, obs(), exp_obs()); end
      checks++;
      if (duty_out > 7'(DMAX) || (!we && (int'(duty_out) - prev > 1 || prev - int'(duty_out) > 1))) begin
        errors++; $display("FAIL rand_range edge=%0d got duty=%0d prev=%0d exp within 0..%0d step<=1", edge_n, duty_out, prev, DMAX);
      end
    end
  endtask

  initial begin
    bus.WE = 1'b0;
    bus.WD = '0;
    test_reset();
    test_jump();
    test_ramp_up();
    test_clamp();
    test_reverse();
    test_step_write();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pwm_fader.md
PWM_FADER -- requirements
Module: pwm_fader

Interface
REQ-001 SHALL have parameter TICK_DIV, default 118_877, meaning clk cycles per ramp tick (one full 1 kHz PWM period).
REQ-002 SHALL have parameter DUTY_MAX, default 100, meaning the highest legal duty value in percent.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port WD  input  32  bus write data: [6:0] target duty, [15:8] ramp rate in ticks per 1% step, other bits ignored.
REQ-006 SHALL have port WE  input  1  bus write enable, one-cycle strobe.
REQ-007 SHALL have port RD  output  32  readback: {15'b0, busy, rate[7:0], 1'b0, current[6:0], 1'b0... packed as [31:17]=0, [16]=busy, [15:8]=rate, [7]=0, [6:0]=current}.
REQ-008 SHALL have port duty_out  output  7  current duty value, drives the PWM peripheral write-data bits [6:0].
REQ-009 SHALL have port duty_we  output  1  one-cycle strobe, drives the PWM peripheral write enable whenever duty_out changes.
REQ-010 SHALL have port busy  output  1  high while current duty differs from target.

Function
REQ-011 SHALL latch target and rate on the clk edge where WE=1, in any state.
REQ-012 SHALL clamp a written target above DUTY_MAX to DUTY_MAX before latching.
REQ-013 SHALL implement states IDLE, WAIT, STEP.
REQ-014 IDLE: on write with clamped target == current -> stay IDLE, no duty_we.
REQ-015 IDLE or WAIT: on write with rate == 0 and target != current -> duty_out = target and duty_we = 1 on the cycle after the write, then IDLE.
REQ-016 IDLE or WAIT: on write with rate != 0 and target != current -> enter WAIT, clear tick counter and tick-count, busy = 1 from the cycle after the write.
REQ-017 WAIT: tick counter counts 0..TICK_DIV-1 and wraps; each wrap increments tick-count; when tick-count reaches rate -> STEP.
REQ-018 STEP (one cycle): duty_out moves by 1 toward target, duty_we = 1 the same cycle duty_out updates; then IDLE if equal to target, else WAIT with counters cleared.
REQ-019 A write in the same cycle as STEP SHALL win: the step is discarded and REQ-014/015/016 apply against the pre-step current.
REQ-020 duty_out SHALL never leave 0..DUTY_MAX, and no step SHALL ever change it by more than 1.
REQ-021 duty_we SHALL be high for exactly one cycle per change of duty_out, and never otherwise.
REQ-022 RD SHALL reflect registered state with no combinational path from WD or WE.

Reset
REQ-023 While rst_n = 0: state IDLE, target = 0, rate = 0, duty_out = 0, duty_we = 0, busy = 0, all counters 0.
REQ-024 Reset asserted mid-ramp SHALL abort immediately, with no duty_we pulse on release.

Structure
REQ-025 A shared pwm_pkg SHALL hold DUTY_MAX, the state encoding, and the RD field bit positions.
REQ-026 Tick generation SHALL be one sub-module, pwm_tick_gen (parameter TICK_DIV, inputs clk, rst_n, clr; output tick).

Verification (bench with TICK_DIV = 4)
REQ-027 Write target 10, rate 0 from reset -> one cycle later duty_out = 10 with a single duty_we pulse; busy never high.
REQ-028 Write target 3, rate 2 from 0 -> duty_out goes 1, 2, 3 at 8-cycle intervals; 3 duty_we pulses; busy drops when duty_out = 3.
REQ-029 Write target 120 -> latched target 100; a downward ramp from 100 to 98 at rate 1 -> 2 pulses, 4 cycles apart.
REQ-030 Mid-ramp (current 5, heading to 20) write target 2, rate 1 -> ramp reverses: 4, 3, 2; no pulse lands less than 4 cycles after the write.
REQ-031 Write with WE in the STEP cycle -> the step is discarded; RD[6:0] is unchanged that cycle.
REQ-032 Assert rst_n low mid-ramp for 1 cycle -> duty_out = 0 and busy = 0 immediately; no duty_we for 20 cycles after release.
